// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the RO-PUF challenge sequencer.
package puf_pkg;

  localparam int CHAL_W = 5;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic int tie_cnt_width(input int num_chal);
    return $clog2(num_chal + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter; expire is high for the single cycle the count sits at zero.
module puf_window_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = load_val;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expire = active_q && (cnt_q == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Walks NUM_CHAL challenges, gates the RO counter banks per challenge and
// compares the two counts into one response bit each.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int NUM_CHAL = 8,
  parameter int WINDOW   = 256,
  parameter int SETTLE   = 4,
  parameter int CLR_CYC  = 2,
  localparam int TIE_W   = tie_cnt_width(NUM_CHAL)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CHAL_W-1:0]   chal_base,
  input  logic [CNT_W-1:0]    count_a,
  input  logic [CNT_W-1:0]    count_b,
  output logic                osc_en,
  output logic                cnt_clr,
  output logic [CHAL_W-1:0]   sel,
  output logic [NUM_CHAL-1:0] response,
  output logic [TIE_W-1:0]    tie_cnt,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;
  localparam int TMR_W = $clog2(max3(WINDOW, SETTLE, CLR_CYC) + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHAL_W-1:0]   sel_q, sel_d;
  logic [NUM_CHAL-1:0] response_q, response_d;
  logic [TIE_W-1:0]    tie_q, tie_d;
  logic                osc_en_q, osc_en_d;
  logic                cnt_clr_q, cnt_clr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_expire;

  puf_window_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    response_d = response_q;
    tie_d      = tie_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CLEAR;
          idx_d      = '0;
          sel_d      = chal_base;
          response_d = '0;
          tie_d      = '0;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(CLR_CYC - 1);
        end
      end
      ST_CLEAR: begin
        if (tmr_expire) begin
          state_d  = ST_RUN;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(WINDOW - 1);
        end
      end
      ST_RUN: begin
        if (tmr_expire) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (tmr_expire) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A tie reads as 0 and is reported separately through tie_cnt.
        response_d[idx_q] = (count_a > count_b);
        if (count_a == count_b) tie_d = tie_q + TIE_W'(1);
        if (idx_q == IDX_W'(NUM_CHAL - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_CLEAR;
          idx_d    = idx_q + IDX_W'(1);
          sel_d    = sel_q + CHAL_W'(1);
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(CLR_CYC - 1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    osc_en_d  = (state_d == ST_RUN);
    cnt_clr_d = (state_d == ST_CLEAR);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      sel_q      <= '0;
      response_q <= '0;
      tie_q      <= '0;
      osc_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      osc_en_q   <= osc_en_d;
      cnt_clr_q  <= cnt_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign osc_en   = osc_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign sel      = sel_q;
  assign response = response_q;
  assign tie_cnt  = tie_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
